pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register, the generic successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a valid bit, a control bundle and a datapath bundle.
- Supports hazard-unit stall (hold), flush (bubble insertion), start gating and asynchronous reset.
- One instance per pipeline boundary; field packing into ctrl_i/data_i is done by the instantiating stage.

---
 rtl/pipe_stage_reg.sv | 80 ++++++++
 tb/tb_pipe_stage_reg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid, control and datapath bundles.
// Optional saturating stall/flush counters under PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
   parameter int              CTRL_W   = 8,
   parameter int              DATA_W   = 128,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0,
   parameter bit              CLR_DATA = 1'b0,
   parameter int              CNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   // Bubbles always carry CTRL_RST so no write enable leaks downstream.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_RST;
         r_data  <= '0;
      end else if (start_i) begin
         if (flush_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
            if (CLR_DATA) r_data <= '0;
         end else if (!stall_i) begin
            r_valid <= valid_i;
            r_ctrl  <= valid_i ? ctrl_i : CTRL_RST;
            r_data  <= data_i;
         end
      end
   end

   assign valid_o = r_valid;
   assign ctrl_o  = r_ctrl;
   assign data_o  = r_data;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_stall_inc;
   logic             w_flush_inc;

   assign w_stall_inc = start_i & ~flush_i & stall_i & r_valid;
   assign w_flush_inc = start_i & flush_i & r_valid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_inc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_inc && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table plus scoreboard queue.
// Counter checks are compiled in only with PIPE_PERF_CNT_EN.
module tb_pipe_stage_reg;

   localparam int   CW  = 8;
   localparam int   DW  = 128;
   localparam int   NW  = 4;
   localparam bit   CLR = 1'b0;
   localparam logic [CW-1:0] CRST = '0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          vin = 1'b0;
   logic [CW-1:0] cin = '0;
   logic [DW-1:0] din = '0;
   logic          vout;
   logic [CW-1:0] cout;
   logic [DW-1:0] dout;
   logic [NW-1:0] scnt;
   logic [NW-1:0] fcnt;

   pipe_stage_reg #(
      .CTRL_W(CW), .DATA_W(DW), .CTRL_RST(CRST),
      .CLR_DATA(CLR), .CNT_W(NW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .stall_i(stall), .flush_i(flush), .valid_i(vin),
      .ctrl_i(cin), .data_i(din),
      .valid_o(vout), .ctrl_o(cout), .data_o(dout)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
`endif
   );

`ifndef PIPE_PERF_CNT_EN
   assign scnt = '0;
   assign fcnt = '0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic          st, sl, fl, v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic          ev;
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
   } vec_t;

   typedef struct {
      logic          v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic [NW-1:0] sc, fc;
      string         nm;
   } exp_t;

   exp_t          sb[$];
   int            n_chk = 0;
   int            n_err = 0;
   logic          m_v = 1'b0;
   logic [NW-1:0] m_sc = '0;
   logic [NW-1:0] m_fc = '0;
   logic [DW-1:0] hd;

   task automatic chk(string nm, logic [255:0] act,
                      logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic step(string nm, logic st, logic sl,
                       logic fl, logic v,
                       logic [CW-1:0] c, logic [DW-1:0] d,
                       logic ev, logic [CW-1:0] ec,
                       logic [DW-1:0] ed);
      exp_t e, g;
      @(negedge clk);
      start = st; stall = sl; flush = fl;
      vin = v; cin = c; din = d;
      if (st && !fl && sl && m_v && m_sc != '1) m_sc++;
      if (st && fl && m_v && m_fc != '1) m_fc++;
      m_v = ev;
      e.v = ev; e.c = ec; e.d = ed;
      e.sc = m_sc; e.fc = m_fc; e.nm = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk(g.nm, {vout, cout, dout}, {g.v, g.c, g.d});
`ifdef PIPE_PERF_CNT_EN
      chk({g.nm, "_cnt"}, {scnt, fcnt}, {g.sc, g.fc});
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", {vout, cout, dout, scnt, fcnt}, '0);
      m_v = 1'b0; m_sc = '0; m_fc = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t tbl[14];

   initial begin
      hd = CLR ? '0 : 128'h5A5A;
      tbl[0]  = '{1,0,0,1,8'hA5,128'h1234, 1,8'hA5,128'h1234};
      tbl[1]  = '{1,0,0,1,8'h3C,128'h33,   1,8'h3C,128'h33};
      tbl[2]  = '{1,1,0,1,8'hFF,128'hFF,   1,8'h3C,128'h33};
      tbl[3]  = '{1,1,0,1,8'hFF,128'hFF,   1,8'h3C,128'h33};
      tbl[4]  = '{1,1,0,1,8'hFF,128'hFF,   1,8'h3C,128'h33};
      tbl[5]  = '{1,0,0,1,8'hFF,128'hFF,   1,8'hFF,128'hFF};
      tbl[6]  = '{1,0,0,1,8'h5A,128'h5A5A, 1,8'h5A,128'h5A5A};
      tbl[7]  = '{1,1,1,1,8'h11,128'h11,   0,8'h00,hd};
      tbl[8]  = '{1,0,0,0,8'hFF,128'h77,   0,8'h00,128'h77};
      tbl[9]  = '{1,0,0,1,8'hC3,128'h99,   1,8'hC3,128'h99};
      tbl[10] = '{0,0,1,1,8'h12,128'h1,    1,8'hC3,128'h99};
      tbl[11] = '{1,0,1,1,8'h12,128'h1,    0,8'h00,
                  CLR ? 128'h0 : 128'h99};
      tbl[12] = '{1,0,1,1,8'h13,128'h2,    0,8'h00,
                  CLR ? 128'h0 : 128'h99};
      tbl[13] = '{1,1,0,1,8'hAA,128'h3,    0,8'h00,
                  CLR ? 128'h0 : 128'h99};

      #1 rst = 1'b1;
      #1;
      chk("rst_state", {vout, cout, dout, scnt, fcnt}, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++)
         step($sformatf("vec%0d", i), tbl[i].st, tbl[i].sl,
              tbl[i].fl, tbl[i].v, tbl[i].c, tbl[i].d,
              tbl[i].ev, tbl[i].ec, tbl[i].ed);

      step("ld_pre", 1,0,0,1, 8'h66, 128'h66, 1, 8'h66, 128'h66);
      step("st_pre", 1,1,0,1, 8'h01, 128'h01, 1, 8'h66, 128'h66);
      do_reset();
      step("post_rst_hold", 1,1,0,1, 8'h02, 128'h02,
           0, 8'h00, 128'h0);
      step("post_rst_ld", 1,0,0,1, 8'hFF, 128'hABC,
           1, 8'hFF, 128'hABC);

      for (int i = 0; i < 20; i++)
         step($sformatf("sat%0d", i), 1,1,0,1, 8'h00, 128'h0,
              1, 8'hFF, 128'hABC);
      step("sat_fl", 1,0,1,1, 8'h00, 128'h0,
           0, 8'h00, CLR ? 128'h0 : 128'hABC);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1);
   end

endmodule
